// File: rtl/div_req_arbiter_if.sv
// Requester-side and DIV-side signals of the DIV request arbiter.
// master = arbiter view, slave = requesters plus DIV instance.
interface div_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 31,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ack;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_q;
  logic              resp_err;
  logic              busy;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic              div_rst;
  logic [W-1:0]      div_q;
  logic              div_rdy;

  modport master (
    input  req, req_a, req_b, div_q, div_rdy,
    output req_ack, resp_valid, resp_id, resp_q, resp_err, busy,
           div_start, div_a, div_b, div_rst
  );

  modport slave (
    output req, req_a, req_b, div_q, div_rdy,
    input  req_ack, resp_valid, resp_id, resp_q, resp_err, busy,
           div_start, div_a, div_b, div_rst
  );
endinterface

// File: rtl/div_req_arbiter.sv
// Round-robin sharing of one modular DIV unit between NREQ requesters,
// with divide-by-zero rejection, completion detection and timeout abort.
module div_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 31,
  parameter int TIMEOUT = 4096,
  parameter int IDW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  div_req_arbiter_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int         CW   = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] PMOD = W'(31'h7fff_ffff);

  logic [1:0]     state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] op_id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [CW-1:0]  cnt;
  logic           abort;
  logic [IDW-1:0] res_id;
  logic [W-1:0]   res_q;
  logic           res_err;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           accept;
  logic           zero_div;

  // Rotating priority search starting at rr.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!gnt_found && bus.req[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign sel_a    = bus.req_a[int'(gnt_id)*W +: W];
  assign sel_b    = bus.req_b[int'(gnt_id)*W +: W];
  assign zero_div = (sel_b == '0) || (sel_b == PMOD);
  // Gated by reset so no ack can leak out while the block is held in reset.
  assign accept   = (state == IDLE) && gnt_found && reset;

  for (genvar i = 0; i < NREQ; i++) begin : g_ack
    assign bus.req_ack[i] = accept && (gnt_id == IDW'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr      <= '0;
      op_id   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      abort   <= 1'b0;
      res_id  <= '0;
      res_q   <= '0;
      res_err <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_id <= gnt_id;
            op_a  <= sel_a;
            op_b  <= sel_b;
            if (zero_div) begin
              res_id  <= gnt_id;
              res_q   <= '0;
              res_err <= 1'b1;
              state   <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A stale div_rdy from the previous operation may still be high on
          // the first WAIT cycle, so only trust it once cnt has advanced.
          if ((cnt != '0) && bus.div_rdy) begin
            res_id  <= op_id;
            res_q   <= bus.div_q;
            res_err <= 1'b0;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_id  <= op_id;
            res_q   <= '0;
            res_err <= 1'b1;
            abort   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          rr    <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = res_id;
  assign bus.resp_q     = res_q;
  assign bus.resp_err   = res_err;
  assign bus.busy       = (state != IDLE);
  assign bus.div_start  = (state == ISSUE);
  assign bus.div_a      = op_a;
  assign bus.div_b      = op_b;
  assign bus.div_rst    = ~reset | abort;

endmodule

// File: tb/tb_div_req_arbiter.sv
// Scoreboard bench for div_req_arbiter with a scripted DIV stub.
module tb_div_req_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 31;
  localparam int IDW  = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_req_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

  div_req_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic         err;
    int           lat;
  } resp_t;

  resp_t        exp_resp[$];
  int           exp_ack[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ack_cyc = 0;
  int           starts = 0;
  int           exp_starts = 0;
  int           rst_pulses = 0;
  logic [W-1:0] cur_a, cur_b;
  logic [W-1:0] sa [NREQ];
  logic [W-1:0] sb [NREQ];

  logic [W-1:0] stub_q;
  int           stub_lat;
  bit           stub_spur;
  int           sk;
  bit           sact;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // DIV stub: rdy at WAIT cycle stub_lat (0 = never), optional stale rdy on cycle 1.
  initial begin
    bus.div_rdy = 1'b0;
    bus.div_q   = '0;
    sact = 0;
    sk   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sact = 0;
        bus.div_rdy = 1'b0;
      end else if (bus.div_start) begin
        sact = 1;
        sk   = 0;
        bus.div_rdy = 1'b0;
      end else if (sact) begin
        sk++;
        bus.div_rdy = (stub_spur && sk == 1) || (stub_lat != 0 && sk == stub_lat);
        bus.div_q   = (stub_lat != 0 && sk == stub_lat) ? stub_q : 31'h5555;
        if (stub_lat != 0 && sk > stub_lat) sact = 0;
      end
    end
  end

  // Ack monitor
  int ea;
  initial forever begin
    @(negedge clk);
    if (bus.req_ack != '0) begin
      chk("ack_onehot", 64'($onehot(bus.req_ack)), 64'd1);
      if (exp_ack.size() == 0) chk("ack_unexpected", 64'(bus.req_ack), 64'd0);
      else begin
        ea = exp_ack.pop_front();
        chk("ack_id", 64'(bus.req_ack), 64'(1 << ea));
        cur_a   = sa[ea];
        cur_b   = sb[ea];
        ack_cyc = cyc;
      end
    end
  end

  // DIV start monitor
  initial forever begin
    @(negedge clk);
    if (bus.div_start) begin
      starts++;
      chk("start_lat", 64'(cyc - ack_cyc), 64'd1);
      chk("div_a", 64'(bus.div_a), 64'(cur_a));
      chk("div_b", 64'(bus.div_b), 64'(cur_b));
    end
    if (reset && bus.div_rst) rst_pulses++;
  end

  // Response monitor
  resp_t r;
  initial forever begin
    @(negedge clk);
    if (bus.resp_valid) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      else begin
        r = exp_resp.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(r.id));
        chk("resp_q", 64'(bus.resp_q), 64'(r.q));
        chk("resp_err", 64'(bus.resp_err), 64'(r.err));
        if (r.lat >= 0) chk("resp_lat", 64'(cyc - ack_cyc), 64'(r.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Raise req[id] and hold until acked; lat: stub WAIT-cycle latency, 0 = timeout.
  task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] q,
                       int lat, bit spur, bit want_resp);
    resp_t e;
    bit got;
    sa[id] = a;
    sb[id] = b;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    stub_q    = q;
    stub_lat  = lat;
    stub_spur = spur;
    e.id = id;
    if (b == '0 || b == 31'h7fffffff) begin
      e.q = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      exp_starts++;
      if (lat == 0) begin e.q = '0; e.err = 1'b1; e.lat = TMO + 2; end
      else          begin e.q = q;  e.err = 1'b0; e.lat = lat + 2; end
    end
    exp_ack.push_back(id);
    if (want_resp) exp_resp.push_back(e);
    bus.req[id] = 1'b1;
    got = 0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ack[id]) got = 1;
    end
    chk("ack_wait", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.req[id] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_resp.size() != 0; n++) @(negedge clk);
    chk("drain", 64'(exp_resp.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n_ack;
    int s0;
    resp_t e;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    stub_q = '0; stub_lat = 3; stub_spur = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_div_rst", 64'(bus.div_rst), 64'd1);
    chk("rst_div_start", 64'(bus.div_start), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Round robin with all four held: acks 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      sa[i] = 31'd6; sb[i] = 31'd3;
      bus.req_a[i*W +: W] = 31'd6;
      bus.req_b[i*W +: W] = 31'd3;
    end
    stub_q = 31'd2; stub_lat = 3; stub_spur = 0;
    foreach (sa[i]) begin end
    for (int k = 0; k < 5; k++) begin
      exp_ack.push_back(k % NREQ);
      e.id = k % NREQ; e.q = 31'd2; e.err = 1'b0; e.lat = 5;
      exp_resp.push_back(e);
      exp_starts++;
    end
    bus.req = '1;
    n_ack = 0;
    for (int n = 0; n < 200 && n_ack < 5; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) n_ack++;
    end
    chk("rr_ack_count", 64'(n_ack), 64'd5);
    @(posedge clk); #1;
    bus.req = '0;
    drain();

    // 6/3 = 2 and 1/2 = 2^30 mod p
    issue(0, 31'd6, 31'd3, 31'd2, 3, 0, 1);
    drain();
    issue(1, 31'd1, 31'd2, 31'h40000000, 2, 0, 1);
    drain();

    // Divide-by-zero forms never start DIV
    s0 = starts;
    issue(2, 31'd5, 31'd0, 31'd0, 3, 0, 1);
    drain();
    issue(2, 31'd5, 31'h7fffffff, 31'd0, 3, 0, 1);
    drain();
    chk("zero_no_start", 64'(starts), 64'(s0));

    // Stale rdy on first WAIT cycle is ignored
    issue(3, 31'd10, 31'd5, 31'd2, 4, 1, 1);
    drain();

    // Timeout abort
    issue(3, 31'd9, 31'd7, 31'd0, 0, 0, 1);
    drain();
    chk("tmo_idle", 64'(bus.busy), 64'd0);
    chk("tmo_rst_pulse", 64'(rst_pulses), 64'd1);

    // Reset mid-WAIT drops the op silently
    issue(1, 31'd6, 31'd3, 31'd2, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_div_rst", 64'(bus.div_rst), 64'd1);
    chk("mid_rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("mid_rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("mid_rst_div_a", 64'(bus.div_a), 64'd0);
    chk("mid_rst_div_b", 64'(bus.div_b), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(0, 31'd6, 31'd3, 31'd2, 3, 0, 1);
    drain();

    chk("total_starts", 64'(starts), 64'(exp_starts));
    chk("total_rst_pulses", 64'(rst_pulses), 64'd1);
    chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
